instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage that generates the program counter, drives the synchronous instruction memory (one-cycle read latency, NOP `32'h11111111` when not enabled or out of range), and delivers instruction/PC pairs to decode over a valid/ready handshake. It sits directly upstream of instruction memory on the request side and downstream of it on the response side. It absorbs decode back-pressure with a two-entry buffer and accepts redirects (branch/jump) from execute.

## Interface
- `RESET_PC`, `32'h01000000`: PC fetched first after reset (instruction memory base).
- `clk` input, 1: single clock; all state updates on its rising edge.
- `reset` input, 1: asynchronous, active-high; clears all state.
- `imemReadEnable` output, 1: request strobe to instruction memory; combinational from state.
- `imemAddress` output, 32: byte address of the request, equal to the current PC.
- `imemInstruction` input, 32: memory data, valid the cycle after a request.
- `redirectValid` input, 1: execute requests a PC change.
- `redirectTarget` input, 32: new PC; sampled when `redirectValid` is high.
- `fetchValid` output, 1: output entry holds an instruction.
- `fetchReady` input, 1: decode accepts this cycle.
- `fetchInstruction` output, 32: instruction word.
- `fetchPc` output, 32: address the instruction was fetched from.

## Operation
- State: `pc`, `pending` (a request was issued last cycle), `respPc`, output entry, skid entry, and `held` = 0..2 occupied entries.
- Transfer: `fetchValid & fetchReady` at a rising edge. `accept` = that condition in the current cycle.
- Issue rule: `imemReadEnable = ~reset & ~redirectValid & ((held - accept) + pending <= 1)`. `imemAddress = pc` always. On issue: `pc <= pc + 4` (mod 2^32, so `0xFFFFFFFC` wraps to `0`), `pending <= 1`, `respPc <= pc`. Otherwise `pending <= 0`.
- Response: when `pending` is high, `{imemInstruction, respPc}` is written.
  - It goes to the output entry if the output is empty or is being accepted with an empty skid; otherwise it goes to the skid entry.
  - The issue rule guarantees a free slot, so the buffer can never overflow. A response arriving while `held==2` after accept is a design error and is covered by an assertion.
- Accept with skid occupied: the skid entry moves to the output in the same edge; any arriving response goes to the skid.
- `imemInstruction` is sampled only when `pending` is high. NOP data produced while not enabled is never captured.
- Misaligned or out-of-range PCs are fetched normally. Memory returns NOP `0x11111111`, which is forwarded as an ordinary instruction with its PC; there is no fault output.
- Redirect, which has priority over every other event:
  - The cycle `redirectValid` is high: no issue; output and skid are cleared; `pending` is cleared, so the response arriving next cycle is dropped; `pc <= redirectTarget`.
  - A transfer coinciding with a redirect is considered squashed. Decode discards it, because the redirect originates downstream.
- Back-to-back redirects: the last one wins; no issue occurs until the first cycle with `redirectValid` low.

## Timing
- Reset values:
  - `pc=RESET_PC`; `pending=0`; `held=0`.
  - `fetchValid=0`; `fetchInstruction=0x11111111`; `fetchPc=0`.
  - `imemReadEnable=0` while `reset` is high.
- First cycle after reset release (C0): issue `RESET_PC`. C1: response captured. C2: `fetchValid=1`, `fetchPc=RESET_PC`.
- Issue-to-valid latency: 2 cycles. Redirect at cycle T: target issued at T+1, `fetchValid` at T+3.
- With `fetchReady` held high: one instruction per cycle, sequential PCs, no bubbles.
- With `fetchReady` low: at most 2 entries are buffered, and issue stops within 1 cycle. When `fetchReady` rises, throughput resumes with no lost or duplicated PC.
- Reset asserted mid-operation: every register clears asynchronously; any in-flight response is discarded; fetch restarts at `RESET_PC`.

## Structure
- Shared package `core_pkg`:
  - `INSTR_WIDTH=32`, `XLEN=32`.
  - `IMEM_BASE_ADDRESS=32'h01000000`.
  - `NOP_INSTRUCTION=32'h11111111`.
  - Typedef `fetch_entry_t {instr[31:0], pc[31:0]}`.
- One sub-module, `fetch_skid_buffer`: 2-entry output/skid storage with a `flush` input, `held` count and push/pop. The PC and issue logic stay in `instruction_fetch`.

## Test plan
- **Reset, then `fetchReady=1` with a memory model:** `fetchPc` reads `0x01000000, 0x01000004, 0x01000008…` from C2, one per cycle, each with the matching memory word.
- **Back-pressure:** `fetchReady=0` for 5 cycles mid-stream. `held` reaches 2; `imemReadEnable` goes low; on release, PCs continue contiguously with no gap and no repeat.
- **Redirect to `0x01000100` while the output and skid are full and a request is pending:** the three stale entries never appear. `fetchPc=0x01000100` appears exactly 3 cycles later.
- **Redirect to misaligned `0x01000102`:** `fetchInstruction=0x11111111`, `fetchPc=0x01000102`; the next PC is `0x01000106`.
- **`RESET_PC=32'hFFFFFFF8`:** fetched PCs are `FFFFFFF8, FFFFFFFC, 00000000`, with NOP data for out-of-range addresses.
- **`reset` asserted for 1 cycle while `held=2`:** outputs return to reset values immediately; the restart sequence matches the first scenario.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-stage types, constants and the issue-credit helper.
package core_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam int XLEN        = 32;

  localparam logic [XLEN-1:0]        IMEM_BASE_ADDRESS = 32'h01000000;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION   = 32'h11111111;
  localparam logic [XLEN-1:0]        PC_STEP           = 32'h00000004;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [XLEN-1:0]        pc;
  } fetch_entry_t;

  localparam fetch_entry_t RESET_ENTRY = '{instr: NOP_INSTRUCTION, pc: 32'h00000000};

  // A new request may go out only if the buffer still has room for it after
  // this cycle's accept and the response already in flight.
  function automatic logic issue_allowed(input logic [1:0] held,
                                         input logic       accept,
                                         input logic       pending);
    logic [2:0] occupancy;
    occupancy = {1'b0, held} - {2'b00, accept} + {2'b00, pending};
    return (occupancy <= 3'd1);
  endfunction
endpackage

// File: rtl/fetch_skid_buffer.sv
// Output entry plus one skid entry absorbing decode back-pressure.
module fetch_skid_buffer
  import core_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic         out_valid,
  output fetch_entry_t out_entry,
  output logic [1:0]   held
);
  logic         out_valid_r;
  logic         skid_valid_r;
  fetch_entry_t out_entry_r;
  fetch_entry_t skid_entry_r;

  logic         pop_s;
  logic         out_valid_next_s;
  logic         skid_valid_next_s;
  fetch_entry_t out_entry_next_s;
  fetch_entry_t skid_entry_next_s;

  assign pop_s = pop & out_valid_r;

  // Next-state selection: flush, refill from skid, fill output, or spill to skid.
  always_comb begin
    out_valid_next_s  = out_valid_r;
    skid_valid_next_s = skid_valid_r;
    out_entry_next_s  = out_entry_r;
    skid_entry_next_s = skid_entry_r;
    if (flush) begin
      out_valid_next_s  = 1'b0;
      skid_valid_next_s = 1'b0;
    end else if (pop_s && skid_valid_r) begin
      out_valid_next_s  = 1'b1;
      out_entry_next_s  = skid_entry_r;
      skid_valid_next_s = push;
      skid_entry_next_s = push ? push_entry : skid_entry_r;
    end else if (pop_s || !out_valid_r) begin
      out_valid_next_s  = push;
      out_entry_next_s  = push ? push_entry : out_entry_r;
    end else if (push) begin
      skid_valid_next_s = 1'b1;
      skid_entry_next_s = push_entry;
    end else begin
      out_valid_next_s  = out_valid_r;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_entry_r  <= RESET_ENTRY;
      skid_entry_r <= RESET_ENTRY;
    end else begin
      out_valid_r  <= out_valid_next_s;
      skid_valid_r <= skid_valid_next_s;
      out_entry_r  <= out_entry_next_s;
      skid_entry_r <= skid_entry_next_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_entry = out_entry_r;
  assign held      = {1'b0, out_valid_r} + {1'b0, skid_valid_r};

  fetch_skid_checker u_checker (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop_s),
    .out_valid  (out_valid_r),
    .skid_valid (skid_valid_r)
  );
endmodule

// File: rtl/fetch_skid_checker.sv
// Invariant checks for the two-entry fetch buffer.
module fetch_skid_checker (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic out_valid,
  input logic skid_valid
);
  // A response must never arrive while both entries stay occupied.
  no_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(push && out_valid && skid_valid && !pop));

  // The skid entry is only ever used behind a full output entry.
  skid_behind_out_a: assert property (@(posedge clk) disable iff (reset)
    (skid_valid |-> out_valid));
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC generation, instruction memory requests and redirect handling.
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = IMEM_BASE_ADDRESS
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imemReadEnable,
  output logic [XLEN-1:0]        imemAddress,
  input  logic [INSTR_WIDTH-1:0] imemInstruction,
  input  logic                   redirectValid,
  input  logic [XLEN-1:0]        redirectTarget,
  output logic                   fetchValid,
  input  logic                   fetchReady,
  output logic [INSTR_WIDTH-1:0] fetchInstruction,
  output logic [XLEN-1:0]        fetchPc
);
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] resp_pc_r;
  logic            pending_r;

  logic            accept_s;
  logic            issue_s;
  logic            push_s;
  logic [1:0]      held_s;
  logic            out_valid_s;
  fetch_entry_t    out_entry_s;
  fetch_entry_t    push_entry_s;

  assign accept_s = out_valid_s & fetchReady;
  assign issue_s  = ~reset & ~redirectValid & issue_allowed(held_s, accept_s, pending_r);
  // A redirect drops the response that is already on its way back.
  assign push_s   = pending_r & ~redirectValid;
  assign push_entry_s = '{instr: imemInstruction, pc: resp_pc_r};

  // Program counter and in-flight request tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r      <= RESET_PC;
      resp_pc_r <= 32'h00000000;
      pending_r <= 1'b0;
    end else begin
      pending_r <= issue_s;
      if (redirectValid) begin
        pc_r <= redirectTarget;
      end else if (issue_s) begin
        pc_r      <= pc_r + PC_STEP;
        resp_pc_r <= pc_r;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  fetch_skid_buffer u_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirectValid),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (accept_s),
    .out_valid  (out_valid_s),
    .out_entry  (out_entry_s),
    .held       (held_s)
  );

  assign imemReadEnable   = issue_s;
  assign imemAddress      = pc_r;
  assign fetchValid       = out_valid_s;
  assign fetchInstruction = out_entry_s.instr;
  assign fetchPc          = out_entry_s.pc;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, stall, redirect, wrap and mid-run reset.
module tb_instruction_fetch;
  localparam logic [31:0] BASE = 32'h01000000;
  localparam logic [31:0] NOP  = 32'h11111111;
  localparam logic [31:0] WRAP = 32'hFFFFFFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectTarget = 32'h0;
  logic        fetchReady = 1'b1;
  logic        ren, valid;
  logic [31:0] addr, imem_data, instr, pc;

  logic        redirect2 = 1'b0;
  logic [31:0] target2 = 32'h0;
  logic        ready2 = 1'b1;
  logic        ren2, valid2;
  logic [31:0] addr2, imem_data2, instr2, pc2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[1:0] == 2'b00 && a >= BASE && a < 32'h01001000) return a ^ 32'hA5A50000;
    return NOP;
  endfunction

  always_ff @(posedge clk) imem_data  <= ren  ? mem_word(addr)  : NOP;
  always_ff @(posedge clk) imem_data2 <= ren2 ? mem_word(addr2) : NOP;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .imemReadEnable(ren), .imemAddress(addr),
    .imemInstruction(imem_data), .redirectValid(redirectValid),
    .redirectTarget(redirectTarget), .fetchValid(valid), .fetchReady(fetchReady),
    .fetchInstruction(instr), .fetchPc(pc)
  );

  instruction_fetch #(.RESET_PC(WRAP)) dut_wrap (
    .clk(clk), .reset(reset), .imemReadEnable(ren2), .imemAddress(addr2),
    .imemInstruction(imem_data2), .redirectValid(redirect2),
    .redirectTarget(target2), .fetchValid(valid2), .fetchReady(ready2),
    .fetchInstruction(instr2), .fetchPc(pc2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic rv, input logic [31:0] rt, input logic rdy);
    @(posedge clk);
    #1;
    reset = r;
    redirectValid = rv;
    redirectTarget = rt;
    fetchReady = rdy;
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input logic v, input logic [31:0] p);
    check({name, ".valid"}, 32'(valid), 32'(v));
    check({name, ".pc"}, pc, v ? p : 32'h0);
    check({name, ".instr"}, instr, v ? mem_word(p) : NOP);
  endtask

  typedef struct {
    logic        rst;
    logic        ready;
    logic        exp_ren;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [1:0]  exp_held;
    logic        exp_valid2;
    logic [31:0] exp_pc2;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, BASE,          1'b0, 32'h0,         2'd0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, BASE,          1'b0, 32'h0,         2'd0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, BASE,          1'b0, 32'h0,         2'd0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h01000004,  1'b0, 32'h0,         2'd0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h01000008,  1'b1, BASE,          2'd1, 1'b1, 32'hFFFFFFF8};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h0100000C,  1'b1, 32'h01000004,  2'd1, 1'b1, 32'hFFFFFFFC};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h01000010,  1'b1, 32'h01000008,  2'd1, 1'b1, 32'h00000000};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h01000014,  1'b1, 32'h0100000C,  2'd1, 1'b1, 32'h00000004};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h01000014,  1'b1, 32'h0100000C,  2'd2, 1'b1, 32'h00000008};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h01000014,  1'b1, 32'h0100000C,  2'd2, 1'b1, 32'h0000000C};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h01000014,  1'b1, 32'h0100000C,  2'd2, 1'b1, 32'h00000010};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h01000014,  1'b1, 32'h0100000C,  2'd2, 1'b1, 32'h00000014};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h01000014,  1'b1, 32'h0100000C,  2'd2, 1'b1, 32'h00000018};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h01000018,  1'b1, 32'h01000010,  2'd1, 1'b1, 32'h0000001C};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h0100001C,  1'b1, 32'h01000014,  2'd1, 1'b1, 32'h00000020};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h01000020,  1'b1, 32'h01000018,  2'd1, 1'b1, 32'h00000024};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 32'h01000024,  1'b1, 32'h0100001C,  2'd1, 1'b1, 32'h00000028};

    #2;
    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].rst, 1'b0, 32'h0, vecs[i].ready);
      check($sformatf("row%0d.ren", i), 32'(ren), 32'(vecs[i].exp_ren));
      check($sformatf("row%0d.addr", i), addr, vecs[i].exp_addr);
      check_out($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
      check($sformatf("row%0d.held", i), 32'(dut.held_s), 32'(vecs[i].exp_held));
      check($sformatf("row%0d.valid2", i), 32'(valid2), 32'(vecs[i].exp_valid2));
      check($sformatf("row%0d.pc2", i), pc2, vecs[i].exp_pc2);
      check($sformatf("row%0d.instr2", i), instr2, NOP);
      check($sformatf("row%0d.ren2", i), 32'(ren2), 32'(!vecs[i].rst));
    end

    // Redirect while the output is full and a response is in flight.
    cyc(1'b0, 1'b1, 32'h01000100, 1'b0);
    check("redir1.ren", 32'(ren), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir1.t1.ren", 32'(ren), 32'h1);
    check("redir1.t1.addr", addr, 32'h01000100);
    check("redir1.t1.held", 32'(dut.held_s), 32'h0);
    check("redir1.t1.valid", 32'(valid), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir1.t2.valid", 32'(valid), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check_out("redir1.t3", 1'b1, 32'h01000100);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check_out("redir1.t4", 1'b1, 32'h01000104);

    // Fill both entries, then back-to-back redirects ending on a misaligned target.
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("redir2.held", 32'(dut.held_s), 32'h2);
    cyc(1'b0, 1'b1, 32'h01000200, 1'b1);
    check("redir2.a.ren", 32'(ren), 32'h0);
    cyc(1'b0, 1'b1, 32'h01000102, 1'b1);
    check("redir2.b.ren", 32'(ren), 32'h0);
    check("redir2.b.valid", 32'(valid), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir2.t1.addr", addr, 32'h01000102);
    check("redir2.t1.ren", 32'(ren), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir2.t2.valid", 32'(valid), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir2.t3.valid", 32'(valid), 32'h1);
    check("redir2.t3.pc", pc, 32'h01000102);
    check("redir2.t3.instr", instr, NOP);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir2.t4.pc", pc, 32'h01000106);
    check("redir2.t4.instr", instr, NOP);

    // One-cycle reset while both entries are held.
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    check("rst.held_before", 32'(dut.held_s), 32'h2);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    check_out("rst.during", 1'b0, 32'h0);
    check("rst.during.ren", 32'(ren), 32'h0);
    check("rst.during.held", 32'(dut.held_s), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst.c0.ren", 32'(ren), 32'h1);
    check("rst.c0.addr", addr, BASE);
    check_out("rst.c0", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check_out("rst.c1", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check_out("rst.c2", 1'b1, BASE);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    check_out("rst.c3", 1'b1, 32'h01000004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
